msb_scan_ctrl: RTL and testbench
================================

Name: msb_scan_ctrl

Overview:
- Sequential controller that finds the most-significant set bit of an N-bit word by scanning it one byte per cycle, from the top byte downward, and stops at the first non-zero byte.
- Trades latency for area versus a fully parallel N-bit MSB finder; one 8-bit priority stage is reused across all bytes.
- Valid/ready handshake on the input and the output; sits between a producer of operand words and a consumer of bit positions.

Parameters:
- N, 32, operand width; multiple of 8, range 8..248 so the result fits in 8 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  producer presents in_data.
- in_ready  out  1  block can accept an operand.
- in_data  in  N  operand word.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_pos  out  8  1-based MSB position (bit k set as highest gives k+1); 0 means no bit set.
- out_found  out  1  1 if any bit of the operand was set.
- busy  out  1  high in SCAN or DONE.
- abort  in  1  synchronous cancel of the operation in progress.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; out_valid=0, out_pos=0, out_found=0, busy=0, in_ready=1.
  - Internal operand register and byte index cleared.
  - Overrides everything, including mid-scan and a pending result.
- The FSM has three states: IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid and in_ready are both high at an edge: latch in_data, set idx=N/8-1, go to SCAN.
  - in_valid with ready low is never captured.
- SCAN:
  - in_ready=0.
  - Each cycle, examine byte idx, i.e. operand[idx*8+7 : idx*8].
  - If that byte is non-zero: out_pos = idx*8 + p, where p (1..8) is the 1-based highest set bit within the byte; out_found=1; go to DONE.
  - Else if idx==0: out_pos=0, out_found=0, go to DONE.
  - Else: idx decrements by 1 and the state stays SCAN.
- DONE:
  - out_valid=1.
  - out_pos and out_found are held stable until the handshake completes.
  - On out_valid and out_ready at an edge: out_valid=0, go to IDLE.
  - in_ready stays 0 throughout DONE, including the handshake cycle; there is no same-cycle bypass. The next operand is accepted no earlier than the edge after the result handshake.
- Latency:
  - Let B be the number of bytes examined: 1 if the top byte is non-zero, up to N/8 for a zero operand or a hit in byte 0.
  - out_valid rises B cycles after the accepting edge.
  - Minimum issue interval is B+2 cycles with out_ready held high.
- Arithmetic:
  - idx*8+p is computed in 8 bits; there is no overflow for N≤248.
  - out_pos and out_found change only on the SCAN→DONE transition, reset or abort.
- abort:
  - In SCAN or DONE: abort=1 at an edge returns the FSM to IDLE, clears out_valid, out_pos and out_found, and discards the operand.
  - In IDLE: abort has no effect, and an operand offered in the same cycle is still accepted.
  - If abort and the out handshake occur in the same cycle, abort wins. The result is considered not delivered, although outputs read identically.
- busy = (state != IDLE).
- in_ready = (state == IDLE).

Test Plan:
- N=32, in_data=0x8000_0000, out_ready=1 → out_valid high 1 cycle after accept; out_pos=32, out_found=1.
- in_data=0x0001_0000 → after 2 scan cycles out_pos=17, out_found=1. Then in_data=0x0000_0001 → after 4 scan cycles out_pos=1, out_found=1.
- in_data=0x0000_0000 → after 4 scan cycles out_pos=0, out_found=0, out_valid=1.
- Backpressure: in_data=0x0000_4000, out_ready=0 for 5 cycles → out_valid stays 1 and out_pos stays 15 throughout. in_ready=0 and in_valid is ignored during this time. Raise out_ready → handshake, IDLE on the next edge, in_ready=1.
- Mid-scan events with in_data=0x0000_00F0:
  - rst_n=0 on the 2nd scan cycle → all outputs 0, in_ready=1 next cycle, no out_valid ever appears for that operand.
  - Repeat with abort=1 instead of reset → identical response.
- Back-to-back issue: in_valid held high with operands 0xFF00_0000 then 0x0000_0080, out_ready=1 → results 32 then 8, in that order. The second accept happens exactly 1 edge after the first output handshake.

Source files
------------

// File: rtl/msb_scan_ctrl.sv
// Byte-serial most-significant-set-bit finder with valid/ready handshakes.
// Scans the operand from the top byte downward, one byte per cycle, reusing a single 8-bit priority stage.
module msb_scan_ctrl #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_pos,
    output logic         out_found,
    output logic         busy,
    input  logic         abort
);

    localparam int unsigned NB    = N / 8;
    localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [N-1:0]     operand_q, operand_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       pos_q, pos_d;
    logic             found_q, found_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    logic [7:0]       byte_c;
    logic [3:0]       bit_pos_c;
    logic [7:0]       hit_pos_c;

    // Select the byte currently under examination
    always_comb begin
        byte_c = '0;
        for (int b = 0; b < int'(NB); b++) begin
            if (idx_q == IDX_W'(b)) begin
                byte_c = operand_q[b*8 +: 8];
            end
        end
    end

    // Shared 8-bit priority stage: 1-based highest set bit, 0 when the byte is empty
    always_comb begin
        bit_pos_c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            if (byte_c[i]) begin
                bit_pos_c = 4'(i + 1);
            end
        end
    end

    assign hit_pos_c = 8'({idx_q, 3'b000}) + 8'(bit_pos_c);

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        idx_d     = idx_q;
        pos_d     = pos_q;
        found_d   = found_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    operand_d = in_data;
                    idx_d     = IDX_W'(NB - 1);
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    operand_d = '0;
                    idx_d     = '0;
                    pos_d     = '0;
                    found_d   = 1'b0;
                end else if (byte_c != 8'd0) begin
                    pos_d   = hit_pos_c;
                    found_d = 1'b1;
                    state_d = S_DONE;
                end else if (idx_q == '0) begin
                    pos_d   = '0;
                    found_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            S_DONE: begin
                // Abort takes priority over a coincident result handshake
                if (abort) begin
                    state_d   = S_IDLE;
                    operand_d = '0;
                    idx_d     = '0;
                    pos_d     = '0;
                    found_d   = 1'b0;
                end else if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
        in_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            operand_q   <= '0;
            idx_q       <= '0;
            pos_q       <= '0;
            found_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            operand_q   <= operand_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            found_q     <= found_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pos   = pos_q;
    assign out_found = found_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_msb_scan_ctrl.sv
// Self-checking bench for msb_scan_ctrl (N=32): directed scenarios plus random operands
// compared against a bit-position reference model.
module tb_msb_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pos;
    logic        out_found;
    logic        busy;
    logic        abort;

    int tests = 0;
    int fails = 0;

    msb_scan_ctrl #(.N(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pos   (out_pos),
        .out_found (out_found),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: 1-based index of the highest set bit, 0 for an all-zero word
    function automatic int ref_pos(input logic [31:0] d);
        for (int i = 31; i >= 0; i--) begin
            if (d[i]) return i + 1;
        end
        return 0;
    endfunction

    // Bytes examined before the scan stops
    function automatic int ref_bytes(input int pos);
        return (pos == 0) ? 4 : 4 - (pos - 1) / 8;
    endfunction

    // After an accepting edge: wait for the result, check it, hold off, then handshake
    task automatic finish_op(input logic [31:0] d, input int hold);
        int exp_pos;
        int cyc;
        exp_pos = ref_pos(d);
        cyc = 0;
        out_ready = (hold == 0);
        while (out_valid !== 1'b1 && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(ref_bytes(exp_pos)));
        chk("out_pos", 32'(out_pos), 32'(exp_pos));
        chk("out_found", 32'(out_found), 32'(exp_pos != 0));
        chk("done_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            tick();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_pos", 32'(out_pos), 32'(exp_pos));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("hs_valid", 32'(out_valid), 32'd0);
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_busy", 32'(busy), 32'd0);
        chk("hs_pos_hold", 32'(out_pos), 32'(exp_pos));
    endtask

    task automatic run_op(input logic [31:0] d, input int hold);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("accept_busy", 32'(busy), 32'd1);
        finish_op(d, hold);
    endtask

    // Kill a scan during its second cycle, by reset or by abort
    task automatic kill_mid_scan(input bit use_abort);
        bit seen;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00F0;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        if (use_abort) abort = 1'b1;
        else           rst_n = 1'b0;
        tick();
        abort = 1'b0;
        rst_n = 1'b1;
        chk("kill_valid", 32'(out_valid), 32'd0);
        chk("kill_pos", 32'(out_pos), 32'd0);
        chk("kill_found", 32'(out_found), 32'd0);
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid === 1'b1) seen = 1'b1;
        end
        chk("kill_no_result", 32'(seen), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int cyc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        abort     = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pos", 32'(out_pos), 32'd0);
        chk("rst_found", 32'(out_found), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        run_op(32'h8000_0000, 0);
        run_op(32'h0001_0000, 0);
        run_op(32'h0000_0001, 0);
        run_op(32'h0000_0000, 0);
        run_op(32'h0000_4000, 5);

        kill_mid_scan(1'b0);
        kill_mid_scan(1'b1);

        // Back-to-back issue with in_valid held high
        in_valid  = 1'b1;
        in_data   = 32'hFF00_0000;
        out_ready = 1'b1;
        tick();
        in_data = 32'h0000_0080;
        tick();
        chk("b2b_first_valid", 32'(out_valid), 32'd1);
        chk("b2b_first_pos", 32'(out_pos), 32'd32);
        tick();
        chk("b2b_hs_in_ready", 32'(in_ready), 32'd1);
        chk("b2b_hs_busy", 32'(busy), 32'd0);
        tick();
        chk("b2b_second_accept", 32'(busy), 32'd1);
        in_valid = 1'b0;
        finish_op(32'h0000_0080, 0);

        // Abort and result handshake in the same cycle: abort wins
        in_valid = 1'b1;
        in_data  = 32'h8000_0000;
        tick();
        in_valid = 1'b0;
        tick();
        chk("ab_done_pos", 32'(out_pos), 32'd32);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done_valid", 32'(out_valid), 32'd0);
        chk("ab_done_pos_clr", 32'(out_pos), 32'd0);
        chk("ab_done_found_clr", 32'(out_found), 32'd0);
        chk("ab_done_in_ready", 32'(in_ready), 32'd1);

        // Abort in IDLE does not block a same-cycle accept
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h0001_0000;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        chk("ab_idle_accept", 32'(busy), 32'd1);
        finish_op(32'h0001_0000, 0);

        // Zero-only latency bound sanity in between random traffic
        cyc = 0;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       d = $urandom >> $urandom_range(0, 32);
                1:       d = 32'd1 << $urandom_range(0, 31);
                2:       d = 32'd0;
                default: d = $urandom;
            endcase
            run_op(d, int'($urandom_range(0, 2)));
            cyc++;
        end
        chk("random_ops_done", 32'(cyc), 32'd40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
